store_rmw_unit: RTL and testbench

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

---
 rtl/store_rmw_unit_pkg.sv | 22 ++
 rtl/store_lane_merge.sv | 23 ++
 rtl/store_rmw_unit.sv | 104 ++++++++++
 tb/tb_store_rmw_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_unit_pkg.sv
// store_rmw_unit_pkg: FSM state encodings, size codes and alignment rule shared by the store unit
package store_rmw_unit_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        DN   = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // A store is rejected when it straddles its natural alignment or uses the reserved size.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == SZ_RSVD) || (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: little-endian insertion of a byte/half/word into an existing memory word
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    output logic [31:0] merged_o
);

    // Overwrite only the addressed lane(s); everything else keeps the old word.
    always_comb begin
        merged_o = old_i;
        if (size_i == SZ_BYTE)
            merged_o[{addr_i, 3'b000} +: 8] = data_i[7:0];
        else if (size_i == SZ_HALF)
            merged_o[{addr_i[1], 4'b0000} +: 16] = data_i[15:0];
        else if (size_i == SZ_WORD)
            merged_o = data_i;
    end

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: turns byte/half/word stores into word-wide read-modify-write memory cycles
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_d;
    logic              busy_q, done_q, err_q, rd_q, wr_q;
    logic [31:0]       merged;

    // The write buffer holds the raw store data until WT replaces it with the merged word.
    store_lane_merge u_merge (
        .old_i    (mem_rdata),
        .data_i   (wdata_q),
        .size_i   (size_q),
        .addr_i   (off_q),
        .merged_o (merged)
    );

    // Next state and operand capture; operands only change on acceptance and on the merge.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        size_d     = size_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                mem_addr_d = addr[ADDR_W-1:2];
                size_d     = size;
                off_d      = addr[1:0];
                wdata_d    = wdata;
                err_d      = misaligned(size, addr[1:0]);
                state_d    = err_d ? DN : (size == SZ_WORD) ? WR : RD;
            end
            RD: state_d = WT;
            WT: begin
                wdata_d = merged;
                state_d = WR;
            end
            WR:      state_d = DN;
            DN:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operands and all outputs are registered, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            size_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            size_q     <= size_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DN;
            err_q      <= err_d;
            rd_q       <= state_d == RD;
            wr_q       <= state_d == WR;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = rd_q;
    assign mem_wr_en = wr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: table vectors, random stores against an arithmetic model, reset and back-to-back sequences
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_rd_en, mem_wr_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_wdata;
    logic [31:0] old_word = '0;
    int total = 0;
    int bad = 0;

    store_rmw_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Memory returns the word exactly one cycle after a read strobe, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_rd_en ? old_word : ~old_word;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] old;
        logic [31:0] ew;
        logic        ee;
        int          lat;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        int n = nbytes(sz);
        return n == 0 || (int'(a[1:0]) % n) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [31:0] a,
                                             input logic [1:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        int sh = 8 * int'(a[1:0]);
        logic [63:0] m, r;
        if (ref_err(a, sz)) return old;
        m = ((64'd1 << (8 * n)) - 64'd1) << sh;
        r = ({32'd0, old} & ~m) | (({32'd0, wd} << sh) & m);
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [1:0] sz);
        return ref_err(a, sz) ? 1 : nbytes(sz) == 4 ? 2 : 4;
    endfunction

    task automatic run_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd, input logic [31:0] old, input logic [31:0] ew,
                             input logic ee, input int lat, input bit hold);
        int rd_n = 0, wr_n = 0, rd_at = 0, wr_at = 0, done_at = 0, ov = 0, idle_n = 0, ma_bad = 0;
        logic got_err = 1'b0;
        logic [31:0] got_w = '0;
        old_word = old;
        addr = a;
        size = sz;
        wdata = wd;
        req = 1'b1;
        for (int k = 1; k <= 10 && done_at == 0; k++) begin
            @(negedge clk);
            if (!busy) idle_n++;
            if (mem_rd_en && mem_wr_en) ov++;
            if ((mem_rd_en || mem_wr_en || done) && mem_addr !== a[31:2]) ma_bad++;
            if (mem_rd_en) begin rd_n++; rd_at = k; end
            if (mem_wr_en) begin wr_n++; wr_at = k; got_w = mem_wdata; end
            if (done) begin done_at = k; got_err = err; end
            if (done_at != 0) req = hold;
            else if (!hold) begin
                req = 1'($urandom_range(0, 1));
                addr = $urandom;
                size = 2'($urandom_range(0, 3));
                wdata = $urandom;
            end
        end
        chk({tag, ".done_at"}, done_at, lat);
        chk({tag, ".err"}, {31'd0, got_err}, {31'd0, ee});
        chk({tag, ".rd_n"}, rd_n, (lat == 4) ? 1 : 0);
        chk({tag, ".rd_at"}, rd_at, (lat == 4) ? 1 : 0);
        chk({tag, ".wr_n"}, wr_n, ee ? 0 : 1);
        chk({tag, ".wr_at"}, wr_at, ee ? 0 : lat - 1);
        if (!ee) chk({tag, ".wdata"}, got_w, ew);
        chk({tag, ".overlap"}, ov, 0);
        chk({tag, ".busy_gap"}, idle_n, 0);
        chk({tag, ".mem_addr"}, ma_bad, 0);
        @(negedge clk);
        chk({tag, ".after"}, {28'd0, busy, done, mem_rd_en, mem_wr_en}, 32'd0);
    endtask

    initial begin
        tv[0] = '{32'h0000_1002, 2'b00, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344, 1'b0, 4};
        tv[1] = '{32'h0000_2002, 2'b01, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'hBEEF_FFFF, 1'b0, 4};
        tv[2] = '{32'h0000_3000, 2'b10, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2};
        tv[3] = '{32'h0000_4001, 2'b10, 32'h1234_5678, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 1};
        tv[4] = '{32'h0000_5000, 2'b11, 32'h1234_5678, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 1};
        tv[5] = '{32'h0000_6001, 2'b01, 32'h1234_5678, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 1};
        tv[6] = '{32'h0000_7000, 2'b00, 32'hFFFF_FF55, 32'h1122_3344, 32'h1122_3355, 1'b0, 4};
        tv[7] = '{32'h0000_8003, 2'b00, 32'h0000_0077, 32'h1122_3344, 32'h7722_3344, 1'b0, 4};
        tv[8] = '{32'h0000_9000, 2'b01, 32'h1234_ABCD, 32'h1122_3344, 32'h1122_ABCD, 1'b0, 4};
        tv[9] = '{32'h0000_A003, 2'b01, 32'h1234_ABCD, 32'h1122_3344, 32'h1122_3344, 1'b1, 1};

        #3;
        chk("reset.ctrl", {27'd0, busy, done, err, mem_rd_en, mem_wr_en}, 32'd0);
        chk("reset.mem_addr", {2'b00, mem_addr}, 32'd0);
        chk("reset.mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_store($sformatf("vec%0d", i), tv[i].a, tv[i].sz, tv[i].wd, tv[i].old,
                      tv[i].ew, tv[i].ee, tv[i].lat, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, wd, old;
            logic [1:0] sz;
            a = $urandom;
            wd = $urandom;
            old = $urandom;
            sz = 2'($urandom_range(0, 3));
            if (i % 3 != 0) a[1:0] = sz == 2'd1 ? {a[1], 1'b0} : sz == 2'd2 ? 2'b00 : a[1:0];
            run_store($sformatf("rnd%0d", i), a, sz, wd, old, ref_word(old, a, sz, wd),
                      ref_err(a, sz), ref_lat(a, sz), 1'b0);
        end

        old_word = 32'h1122_3344;
        addr = 32'h0000_1002;
        size = 2'b00;
        wdata = 32'h0000_00AB;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wt.ctrl", {27'd0, busy, done, err, mem_rd_en, mem_wr_en}, 32'd0);
        chk("rst_wt.mem_addr", {2'b00, mem_addr}, 32'd0);
        chk("rst_wt.mem_wdata", mem_wdata, 32'd0);
        begin
            int stray = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (mem_wr_en || mem_rd_en || done || busy) stray++;
                if (i == 1) rst_n = 1'b1;
            end
            chk("rst_wt.stray", stray, 0);
        end
        run_store("rst_word", 32'h0000_3000, 2'b10, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);

        run_store("b2b_first", 32'h0000_1002, 2'b00, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344, 1'b0, 4, 1'b1);
        run_store("b2b_second", 32'h0000_2002, 2'b01, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'hBEEF_FFFF, 1'b0, 4, 1'b1);
        req = 1'b0;
        @(negedge clk);
        chk("b2b.idle", {30'd0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
